// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core front end: next-PC select codes,
// default trap vectors and the supervisor bit position.
package cpu_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [1:0] PC_SEL_JR     = 2'd3;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

  localparam int KERNEL_BIT = 31;

  // Word offset to byte offset, confined to the 31-bit address field.
  function automatic logic [30:0] branch_off(input logic [15:0] imm16);
    return {{13{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux for the non-trap cases. Address arithmetic runs
// on [30:0] only; bit 31 is the supervisor bit and follows its own rules.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic kbit;
  assign kbit     = pc[KERNEL_BIT];
  assign pc_plus4 = {kbit, pc[30:0] + 31'd4};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_SEL_SEQ:    next_pc = pc_plus4;
      PC_SEL_BRANCH: next_pc = branch_taken ? {kbit, pc_plus4[30:0] + branch_off(imm16)}
                                            : pc_plus4;
      PC_SEL_JUMP:   next_pc = {kbit, pc_plus4[30:28], jtarget, 2'b00};
      // Kernel may return to user through JR; user code can never set bit 31.
      PC_SEL_JR:     next_pc = {jr_target[31] & kbit, jr_target[30:0] & ~31'd3};
      default:       next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, trap vectoring with exception priority,
// latched interrupt request, $k0 save path and retired-instruction counter.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_en,
  input  logic [1:0]         pc_sel,
  input  logic               branch_taken,
  input  logic [15:0]        imm16,
  input  logic [25:0]        jtarget,
  input  logic [31:0]        jr_target,
  input  logic               irq,
  input  logic               illegal_op,
  output logic [31:0]        pc,
  output logic [IMEM_AW-1:0] instr_addr,
  output logic [31:0]        pc_plus4,
  output logic               squash,
  output logic               xp_we,
  output logic [31:0]        xp_wdata,
  output logic               kernel,
  output logic [31:0]        retired
);

  logic        irq_pend;
  logic        exc_take;
  logic        irq_take;
  logic        take;
  logic [31:0] calc_pc;
  logic [31:0] next_pc;

  pc_next_calc u_next (
    .pc           (pc),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .jr_target    (jr_target),
    .pc_plus4     (pc_plus4),
    .next_pc      (calc_pc)
  );

  // Interrupts are only taken in user mode and yield to an exception.
  assign exc_take = pc_en & illegal_op;
  assign irq_take = pc_en & irq_pend & ~pc[KERNEL_BIT] & ~illegal_op;
  assign take     = exc_take | irq_take;

  assign squash     = take;
  assign xp_we      = take;
  assign xp_wdata   = pc;
  assign kernel     = pc[KERNEL_BIT];
  assign instr_addr = pc[IMEM_AW+1:2];

  always_comb begin
    next_pc = calc_pc;
    if (exc_take)      next_pc = EXC_VEC;
    else if (irq_take) next_pc = IRQ_VEC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VEC;
      irq_pend <= 1'b0;
      retired  <= '0;
    end else begin
      // A request arriving in the take cycle itself must not be lost.
      irq_pend <= irq_take ? irq : (irq_pend | irq);
      if (pc_en) begin
        pc <= next_pc;
        if (!take) retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random stimulus, all outputs
// compared every cycle against an address-arithmetic reference model.
module tb_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] jr_target;
  logic        irq;
  logic        illegal_op;
  logic [31:0] pc;
  logic [7:0]  instr_addr;
  logic [31:0] pc_plus4;
  logic        squash;
  logic        xp_we;
  logic [31:0] xp_wdata;
  logic        kernel;
  logic [31:0] retired;

  pc_unit #(.IMEM_AW(8)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_sel(pc_sel),
    .branch_taken(branch_taken), .imm16(imm16), .jtarget(jtarget),
    .jr_target(jr_target), .irq(irq), .illegal_op(illegal_op),
    .pc(pc), .instr_addr(instr_addr), .pc_plus4(pc_plus4), .squash(squash),
    .xp_we(xp_we), .xp_wdata(xp_wdata), .kernel(kernel), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drv(input logic en, input logic [1:0] sel, input logic bt,
                     input logic [15:0] imm, input logic [25:0] jt,
                     input logic [31:0] jr, input logic rq, input logic ill);
    pc_en = en; pc_sel = sel; branch_taken = bt; imm16 = imm;
    jtarget = jt; jr_target = jr; irq = rq; illegal_op = ill;
  endtask

  // One clock: compare outputs against the model, then advance the model.
  task automatic cyc();
    logic        in_user, exc, itk, tk;
    logic [31:0] kb, p4, nx, t;
    int          off;
    #1;
    kb      = m_pc & 32'h8000_0000;
    in_user = (kb == 0);
    exc     = pc_en && illegal_op;
    itk     = pc_en && m_pend && in_user && !illegal_op;
    tk      = exc || itk;
    p4      = kb | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    chk("pc",       pc,                 m_pc);
    chk("instr",    32'(instr_addr),    (m_pc >> 2) & 32'hFF);
    chk("plus4",    pc_plus4,           p4);
    chk("squash",   32'(squash),        32'(tk));
    chk("xp_we",    32'(xp_we),         32'(tk));
    chk("xp_wdata", xp_wdata,           m_pc);
    chk("kernel",   32'(kernel),        32'(!in_user));
    chk("retired",  retired,            m_ret);
    @(posedge clk);
    if (pc_en) begin
      if (exc)      nx = 32'h8000_0008;
      else if (itk) nx = 32'h8000_0004;
      else begin
        case (pc_sel)
          2'd1: begin
            off = int'($signed(imm16)) * 4;
            t   = p4 + 32'(off);
            nx  = branch_taken ? (kb | (t & 32'h7FFF_FFFF)) : p4;
          end
          2'd2:    nx = kb | (p4 & 32'h7000_0000) | (32'(jtarget) << 2);
          2'd3:    nx = (jr_target & kb) | (jr_target & 32'h7FFF_FFFC);
          default: nx = p4;
        endcase
      end
      if (!tk) m_ret = m_ret + 32'd1;
      m_pc = nx;
    end
    m_pend = itk ? irq : (m_pend || irq);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_pc = 32'h8000_0000; m_ret = 0; m_pend = 1'b0;
    chk("rst_pc",     pc,            32'h8000_0000);
    chk("rst_instr",  32'(instr_addr), 32'h0);
    chk("rst_ret",    retired,       32'h0);
    chk("rst_kernel", 32'(kernel),   32'h1);
    chk("rst_squash", 32'(squash),   32'h0);
    chk("rst_xp_we",  32'(xp_we),    32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [31:0] pc0, r0;

  initial begin
    drv(0, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0);
    do_reset();

    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("seq3_pc",     pc,              32'h8000_000C);
    chk("seq3_instr",  32'(instr_addr), 32'd3);
    chk("seq3_ret",    retired,         32'd3);
    chk("seq3_kernel", 32'(kernel),     32'd1);

    drv(1, PC_SEL_JUMP, 0, 0, 26'h10, 0, 0, 0); cyc();
    chk("jump_pc", pc, 32'h8000_0040);
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_0046, 0, 0); cyc();
    chk("jr_user_pc", pc, 32'h0000_0044);
    chk("jr_user_k",  32'(kernel), 32'd0);
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h8000_0000, 0, 0); cyc();
    chk("jr_noraise", pc, 32'h0000_0000);

    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_00E4, 0, 0); cyc();
    drv(1, PC_SEL_BRANCH, 1, 16'hFFE0, 0, 0, 0, 0); cyc();
    chk("br_taken",  pc, 32'h0000_0068);
    chk("br_instr",  32'(instr_addr), 32'd26);
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_00E4, 0, 0); cyc();
    drv(1, PC_SEL_BRANCH, 0, 16'hFFE0, 0, 0, 0, 0); cyc();
    chk("br_not", pc, 32'h0000_00E8);

    // irq pulse lands while PC moves to 0xD8; taken the following cycle
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_00D8, 1, 0); cyc();
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0);
    r0 = retired;
    #1;
    chk("irq_squash", 32'(squash), 32'd1);
    chk("irq_xp_we",  32'(xp_we),  32'd1);
    chk("irq_wdata",  xp_wdata,    32'h0000_00D8);
    cyc();
    chk("irq_vec", pc,      32'h8000_0004);
    chk("irq_ret", retired, r0);

    // irq in kernel waits until JR back to user
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 1, 0); cyc();
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    #1;
    chk("k_no_take", 32'(squash), 32'd0);
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_0100, 0, 0); cyc();
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0);
    #1;
    chk("k_late_take",  32'(squash), 32'd1);
    chk("k_late_wdata", xp_wdata,    32'h0000_0100);
    cyc();
    chk("k_late_vec", pc, 32'h8000_0004);

    // exception wins over a pending irq, which then survives
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 1, 0); cyc();
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_0040, 0, 0); cyc();
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 1);
    #1;
    chk("exc_squash", 32'(squash), 32'd1);
    chk("exc_wdata",  xp_wdata,    32'h0000_0040);
    cyc();
    chk("exc_vec", pc, 32'h8000_0008);
    drv(1, PC_SEL_JR, 0, 0, 0, 32'h0000_0060, 0, 0); cyc();
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pend_kept", 32'(squash), 32'd1);
    cyc();

    // stall
    pc0 = pc; r0 = retired;
    drv(0, PC_SEL_JUMP, 1, 16'h1234, 26'h3FF, 32'h1234_5678, 0, 1);
    repeat (4) cyc();
    chk("stall_pc",  pc,      pc0);
    chk("stall_ret", retired, r0);

    for (int i = 0; i < 400; i++) begin
      drv(($urandom % 8) != 0, 2'($urandom), 1'($urandom), 16'($urandom),
          26'($urandom), $urandom, ($urandom % 10) == 0, ($urandom % 16) == 0);
      cyc();
    end

    // mid-cycle reset takes effect without a clock edge
    drv(1, PC_SEL_SEQ, 0, 0, 0, 0, 0, 0); cyc();
    #2;
    do_reset();
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
